// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback controller.
package regfile_pkg;

  typedef enum logic {StClear, StRun} state_e;

  // Requester index, also used as the round-robin pointer value.
  typedef logic req_idx_t;
  localparam req_idx_t REQ_A = 1'b0;
  localparam req_idx_t REQ_B = 1'b1;

  localparam int unsigned DEFAULT_DEPTH = 5;
  localparam int unsigned NREGS = 2 ** DEFAULT_DEPTH;

  function automatic int unsigned num_regs(input int unsigned depth);
    return 2 ** depth;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr_i names the last winner, which loses a tie.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  req_idx_t   ptr_i,
  output logic [1:0] gnt_o,
  output req_idx_t   ptr_o
);

  always_comb begin
    gnt_o = 2'b00;
    ptr_o = ptr_i;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (ptr_i == REQ_A) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
      if (|gnt_o) ptr_o = gnt_o[REQ_B] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: post-reset clear, two-port writeback
// arbitration with a registered write port, and read-side bypass of that write.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [DEPTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0] a_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [DEPTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0] b_data_i,
  input  logic             stall_i,
  output logic             we_o,
  output logic [DEPTH-1:0] addwrite_o,
  output logic [WIDTH-1:0] datowrite_o,
  input  logic [DEPTH-1:0] addreadrs1_i,
  input  logic [WIDTH-1:0] rs1_rf_i,
  output logic [WIDTH-1:0] rs1_data_o,
  input  logic [DEPTH-1:0] addreadrs2_i,
  input  logic [WIDTH-1:0] rs2_rf_i,
  output logic [WIDTH-1:0] rs2_data_o,
  output logic             init_busy_o
);

  localparam logic [DEPTH-1:0] LastAddr = DEPTH'(num_regs(DEPTH) - 1);

  state_e           state_q;
  logic [DEPTH-1:0] cnt_q;
  logic             we_q;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  req_idx_t         ptr_q;
  req_idx_t         ptr_d;
  logic             busy_q;

  logic [1:0]       gnt;
  logic             hs;
  logic [DEPTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;

  rr_arb2 u_arb (
    .req_i (({b_valid_i, a_valid_i})),
    .en_i  ((state_q == StRun) && !stall_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .ptr_o (ptr_d)
  );

  assign a_ready_o = gnt[REQ_A];
  assign b_ready_o = gnt[REQ_B];
  assign hs        = |gnt;
  assign sel_addr  = gnt[REQ_B] ? b_addr_i : a_addr_i;
  assign sel_data  = gnt[REQ_B] ? b_data_i : a_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= REQ_A;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          // Leave only once the final clear write has been visible for a cycle.
          if (we_q && (addr_q == LastAddr)) begin
            state_q <= StRun;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= cnt_q;
            data_q <= '0;
            cnt_q  <= cnt_q + DEPTH'(1);
          end
        end
        StRun: begin
          we_q <= hs && (sel_addr != '0);
          if (hs) ptr_q <= ptr_d;
          if (hs && (sel_addr != '0)) begin
            addr_q <= sel_addr;
            data_q <= sel_data;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign we_o        = we_q;
  assign addwrite_o  = addr_q;
  assign datowrite_o = data_q;
  assign init_busy_o = busy_q;

  assign rs1_data_o = (we_q && (addr_q == addreadrs1_i) && (addreadrs1_i != '0)) ? data_q
                                                                                 : rs1_rf_i;
  assign rs2_data_o = (we_q && (addr_q == addreadrs2_i) && (addreadrs2_i != '0)) ? data_q
                                                                                 : rs2_rf_i;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural register file attached.
module tb_regfile_wb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        a_valid_i, b_valid_i, stall_i;
  logic        a_ready_o, b_ready_o;
  logic [4:0]  a_addr_i, b_addr_i, addreadrs1_i, addreadrs2_i;
  logic [31:0] a_data_i, b_data_i;
  logic        we_o, init_busy_o;
  logic [4:0]  addwrite_o;
  logic [31:0] datowrite_o, rs1_rf_i, rs2_rf_i, rs1_data_o, rs2_data_o;

  logic [31:0] rf [32];
  logic        rf_seed;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rf_seed) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 | i;
    end else if (we_o) begin
      rf[addwrite_o] <= datowrite_o;
    end
  end

  assign rs1_rf_i = rf[addreadrs1_i];
  assign rs2_rf_i = rf[addreadrs2_i];

  regfile_wb_ctrl #(.WIDTH(32), .DEPTH(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .a_valid_i    (a_valid_i),
    .a_ready_o    (a_ready_o),
    .a_addr_i     (a_addr_i),
    .a_data_i     (a_data_i),
    .b_valid_i    (b_valid_i),
    .b_ready_o    (b_ready_o),
    .b_addr_i     (b_addr_i),
    .b_data_i     (b_data_i),
    .stall_i      (stall_i),
    .we_o         (we_o),
    .addwrite_o   (addwrite_o),
    .datowrite_o  (datowrite_o),
    .addreadrs1_i (addreadrs1_i),
    .rs1_rf_i     (rs1_rf_i),
    .rs1_data_o   (rs1_data_o),
    .addreadrs2_i (addreadrs2_i),
    .rs2_rf_i     (rs2_rf_i),
    .rs2_data_o   (rs2_data_o),
    .init_busy_o  (init_busy_o)
  );

  task automatic test_reset();
    @(negedge clk_i);
    n_checks++; if (we_o !== 1'b0) $display("FAIL rst_we got %b want 0", we_o); else n_pass++;
    n_checks++; if (init_busy_o !== 1'b1) $display("FAIL rst_busy got %b want 1", init_busy_o);
    else n_pass++;
    n_checks++; if (addwrite_o !== 5'd0) $display("FAIL rst_addr got %0d want 0", addwrite_o);
    else n_pass++;
    rf_seed = 1'b0;
    rst_ni = 1'b1;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    a_addr_i = 5'd1; b_addr_i = 5'd2; a_data_i = 32'h1; b_data_i = 32'h2;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (we_o !== 1'b1 || addwrite_o !== 5'(i) || datowrite_o !== 32'h0)
        $display("FAIL clear_write[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=0",
                 i, we_o, addwrite_o, datowrite_o, i);
      else n_pass++;
      n_checks++;
      if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0 || init_busy_o !== 1'b1)
        $display("FAIL clear_ready[%0d] got a=%b b=%b busy=%b want 0 0 1",
                 i, a_ready_o, b_ready_o, init_busy_o);
      else n_pass++;
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (we_o !== 1'b0 || init_busy_o !== 1'b0)
      $display("FAIL clear_done got we=%b busy=%b want 0 0", we_o, init_busy_o);
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      addreadrs1_i = 5'(2 * k); addreadrs2_i = 5'(2 * k + 1);
      @(negedge clk_i);
      n_checks++;
      if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0)
        $display("FAIL cleared_reg[%0d] got %h %h want 0 0", 2 * k, rs1_data_o, rs2_data_o);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    @(negedge clk_i);
    a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'h0000_0005; addreadrs1_i = 5'd5;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0)
      $display("FAIL single_ready got a=%b b=%b want 1 0", a_ready_o, b_ready_o);
    else n_pass++;
    @(negedge clk_i);
    a_valid_i = 1'b0;
    n_checks++;
    if (we_o !== 1'b1 || addwrite_o !== 5'd5 || datowrite_o !== 32'h5)
      $display("FAIL single_write got we=%b addr=%0d data=%h want 1 5 5",
               we_o, addwrite_o, datowrite_o);
    else n_pass++;
    n_checks++;
    if (rs1_data_o !== 32'h5) $display("FAIL single_bypass got %h want 5", rs1_data_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (we_o !== 1'b0 || rs1_data_o !== 32'h5)
      $display("FAIL single_rf got we=%b rs1=%h want 0 5", we_o, rs1_data_o);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic exp_b;
    @(negedge clk_i);
    a_valid_i = 1'b1; a_addr_i = 5'd6; a_data_i = 32'd30;
    b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'd77;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2 == 0);
      #1;
      n_checks++;
      if (a_ready_o !== !exp_b || b_ready_o !== exp_b)
        $display("FAIL contend_grant[%0d] got a=%b b=%b want a=%b b=%b",
                 k, a_ready_o, b_ready_o, !exp_b, exp_b);
      else n_pass++;
      @(negedge clk_i);
      n_checks++;
      if (we_o !== 1'b1 || addwrite_o !== (exp_b ? 5'd7 : 5'd6)
          || datowrite_o !== (exp_b ? 32'd77 : 32'd30))
        $display("FAIL contend_write[%0d] got we=%b addr=%0d data=%0d want 1 %0d %0d", k,
                 we_o, addwrite_o, datowrite_o, exp_b ? 7 : 6, exp_b ? 77 : 30);
      else n_pass++;
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
  endtask

  task automatic test_x0();
    @(negedge clk_i);
    b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'hDEAD_BEEF; addreadrs2_i = 5'd0;
    #1;
    n_checks++;
    if (b_ready_o !== 1'b1 || a_ready_o !== 1'b0)
      $display("FAIL x0_ready got a=%b b=%b want 0 1", a_ready_o, b_ready_o);
    else n_pass++;
    @(negedge clk_i);
    b_valid_i = 1'b0;
    n_checks++;
    if (we_o !== 1'b0) $display("FAIL x0_we got %b want 0", we_o); else n_pass++;
    n_checks++;
    if (rs2_data_o !== 32'h0) $display("FAIL x0_read got %h want 0", rs2_data_o); else n_pass++;
  endtask

  task automatic test_stall();
    @(negedge clk_i);
    a_valid_i = 1'b1; a_addr_i = 5'd9; a_data_i = 32'h99;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1) $display("FAIL stall_pre_ready got %b want 1", a_ready_o);
    else n_pass++;
    @(negedge clk_i);
    stall_i = 1'b1; a_addr_i = 5'd10; a_data_i = 32'hAA;
    n_checks++;
    if (we_o !== 1'b1 || addwrite_o !== 5'd9 || datowrite_o !== 32'h99)
      $display("FAIL stall_inflight got we=%b addr=%0d data=%h want 1 9 99",
               we_o, addwrite_o, datowrite_o);
    else n_pass++;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++;
      if (a_ready_o !== 1'b0) $display("FAIL stall_ready[%0d] got %b want 0", j, a_ready_o);
      else n_pass++;
      @(negedge clk_i);
      n_checks++;
      if (we_o !== 1'b0) $display("FAIL stall_we[%0d] got %b want 0", j, we_o); else n_pass++;
    end
    stall_i = 1'b0;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1) $display("FAIL stall_release got %b want 1", a_ready_o);
    else n_pass++;
    @(negedge clk_i);
    a_valid_i = 1'b0;
    n_checks++;
    if (we_o !== 1'b1 || addwrite_o !== 5'd10 || datowrite_o !== 32'hAA)
      $display("FAIL stall_post_write got we=%b addr=%0d data=%h want 1 10 aa",
               we_o, addwrite_o, datowrite_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int cycles;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (we_o !== 1'b0 || init_busy_o !== 1'b1)
      $display("FAIL rerst_state got we=%b busy=%b want 0 1", we_o, init_busy_o);
    else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (we_o !== 1'b1 || addwrite_o !== 5'(i))
        $display("FAIL reclear[%0d] got we=%b addr=%0d want 1 %0d", i, we_o, addwrite_o, i);
      else n_pass++;
    end
    #1 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (we_o !== 1'b0 || addwrite_o !== 5'd0)
      $display("FAIL async_rst got we=%b addr=%0d want 0 0", we_o, addwrite_o);
    else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (we_o !== 1'b1 || addwrite_o !== 5'd0)
      $display("FAIL clear_restart got we=%b addr=%0d want 1 0", we_o, addwrite_o);
    else n_pass++;
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 40) begin
      @(negedge clk_i);
      cycles++;
    end
    n_checks++;
    if (init_busy_o !== 1'b0) $display("FAIL clear_timeout got busy=%b want 0", init_busy_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    @(negedge clk_i);
    a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h33;
    #1;
    n_checks++;
    if (a_ready_o !== 1'b1) $display("FAIL run_rst_ready got %b want 1", a_ready_o);
    else n_pass++;
    #1 rst_ni = 1'b0;
    a_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (we_o !== 1'b0 || addwrite_o !== 5'd0 || datowrite_o !== 32'h0)
      $display("FAIL run_rst_discard got we=%b addr=%0d data=%h want 0 0 0",
               we_o, addwrite_o, datowrite_o);
    else n_pass++;
    rst_ni = 1'b1;
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 40) begin
      @(negedge clk_i);
      cycles++;
    end
    n_checks++;
    if (init_busy_o !== 1'b0) $display("FAIL run_rst_timeout got busy=%b want 0", init_busy_o);
    else n_pass++;
    addreadrs1_i = 5'd3;
    #1;
    n_checks++;
    if (rs1_data_o !== 32'h0) $display("FAIL run_rst_reg3 got %h want 0", rs1_data_o);
    else n_pass++;
  endtask

  initial begin
    rst_ni = 1'b0; rf_seed = 1'b1; stall_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    a_addr_i = '0; b_addr_i = '0; a_data_i = '0; b_data_i = '0;
    addreadrs1_i = '0; addreadrs2_i = '0;
    @(negedge clk_i);
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_stall();
    test_reset_mid_clear();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
